// File: rtl/rotating_digit_banner_if.sv
// Control and display bus of the rotating digit banner: switch/button side drives
// the controls, the banner drives the digit state and shift strobe.
interface rotating_digit_banner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    logic                          dir;
    logic                          hold;
    logic                          mode;
    logic                          load;
    logic [NUM_DIGITS*DIGIT_W-1:0] load_data;
    logic                          step;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_out;
    logic                          shift_tick;

    modport master (
        output dir, hold, mode, load, load_data, step,
        input  digits_out, shift_tick
    );

    modport slave (
        input  dir, hold, mode, load, load_data, step,
        output digits_out, shift_tick
    );
endinterface

// File: rtl/rotating_digit_banner.sv
// N-digit shift register advancing on a prescaled timebase, with count-in or
// circular rotate, parallel load, and single-step while held.
module rotating_digit_banner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int DIGIT_MAX  = 9,
    parameter int TICK_COUNT = 50_000_000,
    parameter int TICK_W     = 26
) (
    input logic                    clk,
    input logic                    reset,
    rotating_digit_banner_if.slave bus
);
    localparam int VEC_W = NUM_DIGITS * DIGIT_W;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t            MAX_D     = digit_t'(DIGIT_MAX);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);

    logic [VEC_W-1:0]  digits_q;
    logic [VEC_W-1:0]  shifted;
    logic [VEC_W-1:0]  clamped;
    logic [TICK_W-1:0] presc_q;
    logic              tick_q;
    digit_t            d_lo;
    digit_t            d_hi;

    assign d_lo = digits_q[DIGIT_W-1:0];
    assign d_hi = digits_q[VEC_W-1 -: DIGIT_W];

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shifted = '0;
        clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            clamped[i*DIGIT_W +: DIGIT_W] = (bus.load_data[i*DIGIT_W +: DIGIT_W] > MAX_D)
                                          ? MAX_D : bus.load_data[i*DIGIT_W +: DIGIT_W];
        end
        if (bus.dir) begin
            shifted[VEC_W-1:DIGIT_W] = digits_q[VEC_W-DIGIT_W-1:0];
            shifted[DIGIT_W-1:0]     = bus.mode ? d_hi
                                     : ((d_lo == MAX_D) ? '0 : d_lo + digit_t'(1));
        end else begin
            shifted[VEC_W-DIGIT_W-1:0] = digits_q[VEC_W-1:DIGIT_W];
            shifted[VEC_W-1 -: DIGIT_W] = bus.mode ? d_lo
                                        : ((d_hi == '0) ? MAX_D : d_hi - digit_t'(1));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
        end else if (bus.load) begin
            digits_q <= clamped;
            presc_q  <= '0;
            tick_q   <= 1'b0;
        end else if (bus.hold) begin
            // Prescaler is frozen while held; a step shifts without touching it.
            tick_q <= bus.step;
            if (bus.step) begin
                digits_q <= shifted;
            end
        end else if (presc_q == TICK_LAST) begin
            presc_q  <= '0;
            digits_q <= shifted;
            tick_q   <= 1'b1;
        end else begin
            presc_q <= presc_q + TICK_W'(1);
            tick_q  <= 1'b0;
        end
    end

    assign bus.digits_out = digits_q;
    assign bus.shift_tick = tick_q;
endmodule

// File: tb/tb_rotating_digit_banner.sv
// Directed bench for rotating_digit_banner: a 4-digit decimal instance and a
// 6-digit base-6 instance, both with a 4-cycle tick, checked against a queue of expectations.
module tb_rotating_digit_banner;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clk = ~clk;

    rotating_digit_banner_if #(.NUM_DIGITS(4), .DIGIT_W(4)) ia ();
    rotating_digit_banner_if #(.NUM_DIGITS(6), .DIGIT_W(3)) ib ();

    rotating_digit_banner #(
        .NUM_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(9), .TICK_COUNT(4), .TICK_W(3)
    ) dut_a (
        .clk  (clk),
        .reset(reset_a),
        .bus  (ia)
    );

    rotating_digit_banner #(
        .NUM_DIGITS(6), .DIGIT_W(3), .DIGIT_MAX(5), .TICK_COUNT(4), .TICK_W(3)
    ) dut_b (
        .clk  (clk),
        .reset(reset_b),
        .bus  (ib)
    );

    typedef struct packed {
        logic [23:0] d;
        logic        t;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;
    int    e_b[6];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input string tag, input logic [23:0] d, input logic t);
        exp_q.push_back('{d: d, t: t});
        tag_q.push_back(tag);
    endtask

    task automatic compare(input string tag, input logic [24:0] obs, input logic [24:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed digits=%h tick=%b expected digits=%h tick=%b",
                   tag, obs[24:1], obs[0], exp_v[24:1], exp_v[0]);
        end
    endtask

    // Push the expectation, clock the DUT once, then pop and compare.
    task automatic step_a(input string tag, input logic [23:0] d, input logic t);
        exp_t  e;
        string s;
        push_exp(tag, d, t);
        tick();
        e = exp_q.pop_front();
        s = tag_q.pop_front();
        compare(s, {24'(ia.digits_out), ia.shift_tick}, {e.d, e.t});
    endtask

    task automatic step_b(input string tag, input logic [23:0] d, input logic t);
        exp_t  e;
        string s;
        push_exp(tag, d, t);
        tick();
        e = exp_q.pop_front();
        s = tag_q.pop_front();
        compare(s, {24'(ib.digits_out), ib.shift_tick}, {e.d, e.t});
    endtask

    task automatic period_a(input string tag, input logic [23:0] prev, input logic [23:0] nxt);
        repeat (3) step_a(tag, prev, 1'b0);
        step_a(tag, nxt, 1'b1);
    endtask

    function automatic logic [23:0] pack_b();
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v[i*3 +: 3] = 3'(e_b[i]);
        return v;
    endfunction

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        ia.dir = 1'b1; ia.hold = 1'b0; ia.mode = 1'b0; ia.load = 1'b0; ia.step = 1'b0;
        ia.load_data = '0;
        ib.dir = 1'b1; ib.hold = 1'b0; ib.mode = 1'b0; ib.load = 1'b0; ib.step = 1'b0;
        ib.load_data = '0;
        @(negedge clk);

        // Reset state, then free-run count-in left.
        step_a("a_reset", 24'h0000, 1'b0);
        reset_a = 1'b0;
        period_a("a_run1", 24'h0000, 24'h0001);
        period_a("a_run2", 24'h0001, 24'h0012);
        period_a("a_run3", 24'h0012, 24'h0123);
        period_a("a_run4", 24'h0123, 24'h1234);

        // Count-in wrap: d0 9->0 going left, d3 0->9 going right.
        ia.load = 1'b1; ia.load_data = 16'h9879;
        step_a("a_load_9879", 24'h9879, 1'b0);
        ia.load = 1'b0;
        period_a("a_wrap_left", 24'h9879, 24'h8790);
        ia.dir = 1'b0; ia.load = 1'b1; ia.load_data = 16'h0123;
        step_a("a_load_0123", 24'h0123, 1'b0);
        ia.load = 1'b0;
        period_a("a_wrap_right", 24'h0123, 24'h9012);

        // Circular rotate both ways; four left rotations restore the pattern.
        ia.mode = 1'b1; ia.dir = 1'b1; ia.load = 1'b1; ia.load_data = 16'h1234;
        step_a("a_load_rot", 24'h1234, 1'b0);
        ia.load = 1'b0;
        period_a("a_rot_l1", 24'h1234, 24'h2341);
        period_a("a_rot_l2", 24'h2341, 24'h3412);
        period_a("a_rot_l3", 24'h3412, 24'h4123);
        period_a("a_rot_l4", 24'h4123, 24'h1234);
        ia.dir = 1'b0; ia.load = 1'b1;
        step_a("a_load_rot_r", 24'h1234, 1'b0);
        ia.load = 1'b0;
        period_a("a_rot_r1", 24'h1234, 24'h4123);

        // Clamp on load, then stepping while held with the prescaler parked at 2.
        ia.mode = 1'b0; ia.dir = 1'b1; ia.load = 1'b1; ia.load_data = 16'hF2F1;
        step_a("a_clamp", 24'h9291, 1'b0);
        ia.load = 1'b0;
        step_a("a_pre_hold", 24'h9291, 1'b0);
        step_a("a_pre_hold", 24'h9291, 1'b0);
        ia.hold = 1'b1; ia.step = 1'b1;
        step_a("a_step1", 24'h2912, 1'b1);
        step_a("a_step2", 24'h9123, 1'b1);
        step_a("a_step3", 24'h1234, 1'b1);
        ia.step = 1'b0;
        step_a("a_held", 24'h1234, 1'b0);
        ia.hold = 1'b0; ia.step = 1'b1;
        step_a("a_step_ignored", 24'h1234, 1'b0);
        ia.step = 1'b0;
        step_a("a_presc_kept", 24'h2345, 1'b1);

        // Hold raised on the terminal-count cycle defers the shift until release.
        repeat (3) step_a("a_to_terminal", 24'h2345, 1'b0);
        ia.hold = 1'b1;
        step_a("a_term_held", 24'h2345, 1'b0);
        step_a("a_term_held", 24'h2345, 1'b0);
        ia.hold = 1'b0;
        step_a("a_term_release", 24'h3456, 1'b1);
        period_a("a_period_resume", 24'h3456, 24'h4567);

        // Load beats step; reset beats load.
        ia.hold = 1'b1; ia.step = 1'b1; ia.load = 1'b1; ia.load_data = 16'h5555;
        step_a("a_load_vs_step", 24'h5555, 1'b0);
        ia.hold = 1'b0; ia.step = 1'b0; ia.load = 1'b0;
        step_a("a_after_load", 24'h5555, 1'b0);
        reset_a = 1'b1; ia.load = 1'b1; ia.load_data = 16'h9999;
        step_a("a_reset_vs_load", 24'h0000, 1'b0);
        reset_a = 1'b0; ia.load = 1'b0;

        // Six base-6 digits: twelve count-in shifts, d0 runs 1..5,0 twice.
        step_b("b_reset", 24'h0, 1'b0);
        reset_b = 1'b0;
        for (int i = 0; i < 6; i++) e_b[i] = 0;
        for (int k = 1; k <= 12; k++) begin
            repeat (3) step_b("b_wait", pack_b(), 1'b0);
            for (int i = 5; i >= 1; i--) e_b[i] = e_b[i-1];
            e_b[0] = (e_b[0] == 5) ? 0 : e_b[0] + 1;
            step_b("b_shift", pack_b(), 1'b1);
            compare("b_d0_seq", {22'(ib.digits_out[2:0]), 3'b000},
                    {22'(k % 6), 3'b000});
        end
        step_b("b_mid_period", pack_b(), 1'b0);
        step_b("b_mid_period", pack_b(), 1'b0);
        reset_b = 1'b1;
        step_b("b_reset_mid", 24'h0, 1'b0);
        reset_b = 1'b0;

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drained: observed %0d left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rotating_digit_banner.md
# rotating_digit_banner

Parametrised successor to the 4-digit rotating number banner: an N-digit BCD-style shift register that advances on a prescaled timebase and feeds the seven-segment display multiplexer. It adds configurable digit count, digit modulus and tick period, plus circular-rotate mode, parallel load, single-step while held, and a shift-strobe output. Sits between the board's switch/button conditioning logic and the display scan driver.

## Interface
- NUM_DIGITS, 4, number of digit cells (≥2)
- DIGIT_W, 4, bits per digit
- DIGIT_MAX, 9, highest legal digit value (≤ 2^DIGIT_W−1)
- TICK_COUNT, 50_000_000, clk cycles per automatic shift (≥2)
- TICK_W, 26, prescaler width (2^TICK_W ≥ TICK_COUNT)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- dir  in  1  1 = shift toward higher index (left), 0 = toward index 0 (right)
- hold  in  1  active-high freeze of prescaler and digits
- mode  in  1  0 = count-in (new digit derived ±1), 1 = circular rotate
- load  in  1  one-cycle pulse: parallel load
- load_data  in  NUM_DIGITS*DIGIT_W  digit i at [i*DIGIT_W +: DIGIT_W]
- step  in  1  one-cycle pulse: single shift, honoured only while hold=1
- digits_out  out  NUM_DIGITS*DIGIT_W  registered digit state, same packing
- shift_tick  out  1  registered; high for exactly the cycle in which digits_out first shows a shifted value

## Operation
- Per-edge priority: reset > load > hold (with step) > free-run.
- reset: all digits 0, prescaler 0, shift_tick 0.
- load: digit i ← min(load_data digit i, DIGIT_MAX); prescaler ← 0; shift_tick 0; ignores hold, step, dir.
- hold=1: prescaler and digits keep value. If step=1 same cycle, perform one shift (rules below); prescaler still unchanged.
- hold=0: prescaler increments; when prescaler == TICK_COUNT−1 it wraps to 0 and one shift is performed. step ignored.
- Shift, dir=1: d[i] ← d[i−1] for i=N−1..1; d[0] ← mode=1 ? old d[N−1] : (old d[0] == DIGIT_MAX ? 0 : old d[0]+1).
- Shift, dir=0: d[i] ← d[i+1] for i=0..N−2; d[N−1] ← mode=1 ? old d[0] : (old d[N−1] == 0 ? DIGIT_MAX : old d[N−1]−1).
- Arithmetic is modulo DIGIT_MAX+1 in DIGIT_W bits; digits never exceed DIGIT_MAX after reset or load.
- dir and mode are sampled only on the shifting edge; changing them mid-period has no other effect and does not reset the prescaler.

## Timing
- Free-run shift period exactly TICK_COUNT cycles; first shift after reset/load/hold-release lands TICK_COUNT − (prescaler value) cycles later.
- digits_out and shift_tick change on the same edge; latency from prescaler terminal value to visible shift is 1 edge.
- step: shift visible 1 edge after step sampled high; back-to-back step pulses give one shift per cycle.
- shift_tick asserts for one cycle per shift (auto or step), never on load or reset.
- hold asserted on the terminal-count cycle suppresses that shift; the prescaler stays at TICK_COUNT−1, and the shift happens on the first edge after hold drops.
- load and step in the same cycle: load wins, no shift, shift_tick 0.
- reset mid-period discards the partial count; reset concurrent with load: reset wins.

## Test plan
- Defaults but TICK_COUNT=4; reset, dir=1, mode=0, hold=0 → digits (d3..d0) 0000, 0001, 0012, 0123 every 4 cycles, then 1234; shift_tick one-cycle pulses coincide.
- Load 9,8,7,9 (d3..d0), dir=1, mode=0 → next shift gives 8,7,9,0 (d0 wraps 9→0); dir=0 from load 0,1,2,3 → 9,0,1,2 (d3 wraps 0→9).
- mode=1, load 1,2,3,4, dir=1 → 2,3,4,1; dir=0 from 1,2,3,4 → 4,1,2,3; N shifts return the original pattern.
- load_data digit 0xF with DIGIT_MAX=9 → stored as 9; hold=1 with three step pulses → exactly three shifts, prescaler value unchanged; step with hold=0 → no extra shift.
- hold raised on terminal cycle → no shift while held; release → shift on next edge, then period TICK_COUNT resumes.
- NUM_DIGITS=6, DIGIT_W=3, DIGIT_MAX=5: count-in left for 12 shifts → d0 sequence 1..5,0,1..5,0; reset asserted mid-period → all zero next edge, shift_tick 0.
